axil_wr_fifo_push: RTL and testbench

//  AXI4-Lite write-channel slave that converts each write transaction into one

---
 rtl/axil_wr_fifo_push.sv | 101 ++++++++++
 tb/tb_axil_wr_fifo_push.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/axil_wr_fifo_push.sv
// AXI4-Lite write slave that turns each AW+W pair into a single async-FIFO push.
// The B response is returned only after the word is pushed, or after it is rejected for a partial strobe.
module axil_wr_fifo_push #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int ERR_W  = 8
) (
  input  logic                     wclk,
  input  logic                     wrst_n,
  input  logic [ADDR_W-1:0]        s_awaddr,
  input  logic                     s_awvalid,
  output logic                     s_awready,
  input  logic [DATA_W-1:0]        s_wdata,
  input  logic [DATA_W/8-1:0]      s_wstrb,
  input  logic                     s_wvalid,
  output logic                     s_wready,
  output logic [1:0]               s_bresp,
  output logic                     s_bvalid,
  input  logic                     s_bready,
  input  logic                     wfull,
  output logic                     winc,
  output logic [ADDR_W+DATA_W-1:0] wdata,
  output logic [ERR_W-1:0]         err_cnt
);

  typedef enum logic [1:0] {COLLECT, PUSH, RESP} state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  state_t                r_state, w_state_nxt;
  logic                  r_aw_held, r_w_held;
  logic [ADDR_W-1:0]     r_aw_addr;
  logic [DATA_W-1:0]     r_w_data;
  logic [DATA_W/8-1:0]   r_w_strb;
  logic [1:0]            r_bresp;
  logic [ERR_W-1:0]      r_err_cnt;

  logic w_aw_fire, w_w_fire, w_strb_ok, w_b_fire, w_reject;

  assign s_awready = (r_state == COLLECT) & ~r_aw_held;
  assign s_wready  = (r_state == COLLECT) & ~r_w_held;
  assign w_aw_fire = s_awvalid & s_awready;
  assign w_w_fire  = s_wvalid & s_wready;
  assign w_strb_ok = &r_w_strb;
  assign w_reject  = (r_state == PUSH) & ~w_strb_ok;

  // Push only from registered state; wfull gates it so the FIFO never overflows.
  assign winc      = (r_state == PUSH) & ~wfull & w_strb_ok;
  assign s_bvalid  = (r_state == RESP);
  assign w_b_fire  = s_bvalid & s_bready;
  assign s_bresp   = r_bresp;
  assign err_cnt   = r_err_cnt;
  // Holding registers are frozen from PUSH until the B handshake, so wdata is stable.
  assign wdata     = {r_aw_addr, r_w_data};

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      COLLECT: if ((r_aw_held | w_aw_fire) & (r_w_held | w_w_fire)) w_state_nxt = PUSH;
      PUSH:    if (w_reject | winc) w_state_nxt = RESP;
      RESP:    if (w_b_fire) w_state_nxt = COLLECT;
      default: w_state_nxt = COLLECT;
    endcase
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_state   <= COLLECT;
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_aw_addr <= '0;
      r_w_data  <= '0;
      r_w_strb  <= '0;
      r_bresp   <= RESP_OKAY;
      r_err_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_aw_fire) begin
        r_aw_held <= 1'b1;
        r_aw_addr <= s_awaddr;
      end
      if (w_w_fire) begin
        r_w_held <= 1'b1;
        r_w_data <= s_wdata;
        r_w_strb <= s_wstrb;
      end
      if (w_reject) begin
        r_bresp <= RESP_SLVERR;
        if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + 1'b1;
      end else if (winc) begin
        r_bresp <= RESP_OKAY;
      end
      if (w_b_fire) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axil_wr_fifo_push.sv
// Directed bench for axil_wr_fifo_push: handshake ordering, backpressure, rejects, async reset.
module tb_axil_wr_fifo_push;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int ERR_W  = 8;

  logic                     wclk = 1'b0;
  logic                     wrst_n;
  logic [ADDR_W-1:0]        s_awaddr;
  logic                     s_awvalid;
  logic                     s_awready;
  logic [DATA_W-1:0]        s_wdata;
  logic [DATA_W/8-1:0]      s_wstrb;
  logic                     s_wvalid;
  logic                     s_wready;
  logic [1:0]               s_bresp;
  logic                     s_bvalid;
  logic                     s_bready;
  logic                     wfull;
  logic                     winc;
  logic [ADDR_W+DATA_W-1:0] wdata;
  logic [ERR_W-1:0]         err_cnt;

  int checks = 0;
  int failures = 0;
  int winc_cnt = 0;
  int ovf_cnt = 0;

  axil_wr_fifo_push #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ERR_W(ERR_W)) dut (
    .wclk(wclk), .wrst_n(wrst_n),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .wfull(wfull), .winc(winc), .wdata(wdata), .err_cnt(err_cnt)
  );

  always #5 wclk = ~wclk;

  // Pushes are counted at the edge that would commit them to the FIFO.
  always @(posedge wclk) begin
    if (winc) winc_cnt++;
    if (winc && wfull) ovf_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge wclk);
    #1;
  endtask

  task automatic send(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                      input logic [DATA_W/8-1:0] st);
    s_awaddr = a; s_wdata = d; s_wstrb = st;
    s_awvalid = 1'b1; s_wvalid = 1'b1;
    step();
    s_awvalid = 1'b0; s_wvalid = 1'b0;
  endtask

  // Full transaction with a bounded wait for B; bready pulsed for one handshake.
  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                          input logic [DATA_W/8-1:0] st);
    int n;
    send(a, d, st);
    n = 0;
    while (!s_bvalid && n < 20) begin
      step();
      n++;
    end
    if (n >= 20) chk("bvalid_timeout", 64'(s_bvalid), 64'd1);
    s_bready = 1'b1;
    step();
    s_bready = 1'b0;
  endtask

  initial begin
    int w0;
    wrst_n = 1'b0; s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wstrb = '0;
    s_wvalid = 1'b0; s_bready = 1'b0; wfull = 1'b0;
    repeat (3) step();
    @(negedge wclk) wrst_n = 1'b1;
    step();

    // reset state
    chk("rst_awready", 64'(s_awready), 64'd1);
    chk("rst_wready",  64'(s_wready),  64'd1);
    chk("rst_bvalid",  64'(s_bvalid),  64'd0);
    chk("rst_winc",    64'(winc),      64'd0);
    chk("rst_wdata",   64'(wdata),     64'd0);
    chk("rst_errcnt",  64'(err_cnt),   64'd0);

    // 1: AW and W together
    send(8'h10, 32'hDEADBEEF, 4'hF);
    chk("t1_winc",    64'(winc),  64'd1);
    chk("t1_wdata",   64'(wdata), 64'h10_DEADBEEF);
    chk("t1_bvalid0", 64'(s_bvalid), 64'd0);
    chk("t1_awready", 64'(s_awready), 64'd0);
    step();
    chk("t1_bvalid",  64'(s_bvalid), 64'd1);
    chk("t1_bresp",   64'(s_bresp),  64'd0);
    chk("t1_winc_off", 64'(winc),    64'd0);
    s_bready = 1'b1;
    step();
    s_bready = 1'b0;
    chk("t1_back_collect", 64'(s_awready), 64'd1);
    chk("t1_bvalid_off", 64'(s_bvalid), 64'd0);
    chk("t1_pushes", 64'(winc_cnt), 64'd1);

    // 2: W two cycles before AW
    s_wdata = 32'h12345678; s_wstrb = 4'hF; s_wvalid = 1'b1;
    step();
    s_wvalid = 1'b0;
    chk("t2_wready0",  64'(s_wready),  64'd0);
    chk("t2_awready1", 64'(s_awready), 64'd1);
    chk("t2_nowinc_a", 64'(winc), 64'd0);
    step();
    chk("t2_nowinc_b", 64'(winc), 64'd0);
    s_awaddr = 8'h22; s_awvalid = 1'b1;
    step();
    s_awvalid = 1'b0;
    chk("t2_winc",  64'(winc),  64'd1);
    chk("t2_wdata", 64'(wdata), 64'h22_12345678);
    step();
    chk("t2_bvalid", 64'(s_bvalid), 64'd1);
    s_bready = 1'b1;
    step();
    s_bready = 1'b0;
    step();
    chk("t2_pushes", 64'(winc_cnt), 64'd2);

    // 3: wfull held 5 cycles in PUSH
    wfull = 1'b1;
    send(8'h33, 32'hCAFEF00D, 4'hF);
    for (int i = 0; i < 5; i++) begin
      chk("t3_stall_winc",   64'(winc),     64'd0);
      chk("t3_stall_bvalid", 64'(s_bvalid), 64'd0);
      step();
    end
    wfull = 1'b0;
    #1;
    chk("t3_winc",  64'(winc),  64'd1);
    chk("t3_wdata", 64'(wdata), 64'h33_CAFEF00D);
    step();
    chk("t3_bvalid", 64'(s_bvalid), 64'd1);
    chk("t3_bresp",  64'(s_bresp),  64'd0);
    s_bready = 1'b1;
    step();
    s_bready = 1'b0;
    chk("t3_pushes", 64'(winc_cnt), 64'd3);

    // 4: partial strobe rejected, counter saturates
    send(8'h44, 32'h0000ABCD, 4'b0011);
    chk("t4_nowinc", 64'(winc), 64'd0);
    step();
    chk("t4_bvalid", 64'(s_bvalid), 64'd1);
    chk("t4_bresp",  64'(s_bresp),  64'd2);
    chk("t4_errcnt", 64'(err_cnt),  64'd1);
    s_bready = 1'b1;
    step();
    s_bready = 1'b0;
    for (int i = 0; i < 299; i++) do_write(8'h44, 32'h1, 4'b0011);
    chk("t4_err_sat",  64'(err_cnt),  64'd255);
    chk("t4_no_push",  64'(winc_cnt), 64'd3);

    // 5: async reset while stalled in PUSH
    wfull = 1'b1;
    send(8'h55, 32'h55555555, 4'hF);
    #3 wrst_n = 1'b0;
    #1;
    chk("t5_winc",   64'(winc),     64'd0);
    chk("t5_bvalid", 64'(s_bvalid), 64'd0);
    chk("t5_bresp",  64'(s_bresp),  64'd0);
    chk("t5_wdata",  64'(wdata),    64'd0);
    chk("t5_errcnt", 64'(err_cnt),  64'd0);
    wfull = 1'b0;
    @(negedge wclk) wrst_n = 1'b1;
    step();
    chk("t5_awready", 64'(s_awready), 64'd1);
    w0 = winc_cnt;
    send(8'h66, 32'h0BADC0DE, 4'hF);
    chk("t5_fresh_winc",  64'(winc),  64'd1);
    chk("t5_fresh_wdata", 64'(wdata), 64'h66_0BADC0DE);
    step();
    chk("t5_fresh_bresp", 64'(s_bresp), 64'd0);
    s_bready = 1'b1;
    step();
    s_bready = 1'b0;
    chk("t5_pushes", 64'(winc_cnt - w0), 64'd1);

    // 6: bready low 4 cycles in RESP with new requests pending
    w0 = winc_cnt;
    send(8'h77, 32'h77777777, 4'hF);
    step();
    s_awaddr = 8'h88; s_wdata = 32'h88888888; s_awvalid = 1'b1; s_wvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t6_bvalid",  64'(s_bvalid),  64'd1);
      chk("t6_bresp",   64'(s_bresp),   64'd0);
      chk("t6_awready", 64'(s_awready), 64'd0);
      chk("t6_wready",  64'(s_wready),  64'd0);
      chk("t6_winc",    64'(winc),      64'd0);
      step();
    end
    s_bready = 1'b1;
    step();
    s_bready = 1'b0; s_awvalid = 1'b0; s_wvalid = 1'b0;
    chk("t6_bvalid_off", 64'(s_bvalid), 64'd0);
    chk("t6_pushes", 64'(winc_cnt - w0), 64'd1);

    chk("no_overflow", 64'(ovf_cnt), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
